// File: rtl/hdmi_timing_detect.sv
// hdmi_timing_detect
//
// Sync-side video timing receiver. Samples hsync/vsync/video_on on ce cycles,
// measures line length, lines per frame, active width and active height, and
// declares lock after LOCK_FRAMES consecutive identical good frames. While
// locked it emits recovered pixel coordinates.
//
// Optional feature: define HDMI_TIMING_DETECT_ERRCNT_EN to build the
// saturating lock-loss counter behind err_count; otherwise err_count is 0.
//
// Ports:
//   pixel_clk   pixel clock, single clock domain
//   reset_n     synchronous active-low reset, overrides ce
//   ce          sample enable; state advances only when ce=1
//   hsync       line sync, rising edge starts a line
//   vsync       frame sync, rising edge starts a frame
//   video_on    active-pixel qualifier
//   h_total     ce cycles per line (last locked frame)
//   v_total     hsync rises per frame (last locked frame)
//   h_active    video_on cycles per active line (last locked frame)
//   v_active    active lines per frame (last locked frame)
//   pixel_x     active column, 0-based
//   pixel_y     active row, 0-based
//   pixel_valid locked & video_on, aligned with pixel_x/pixel_y
//   locked      format stable
//   frame_start one-cycle pulse per vsync rise
//   err_count   lock-loss count (0 when the counter is not built)
module hdmi_timing_detect #(
    parameter int unsigned CW          = 11,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned H_MIN       = 16
) (
    input  logic          pixel_clk,
    input  logic          reset_n,
    input  logic          ce,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          video_on,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] v_total,
    output logic [CW-1:0] h_active,
    output logic [CW-1:0] v_active,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          pixel_valid,
    output logic          locked,
    output logic          frame_start,
    output logic [7:0]    err_count
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    // clog2(N) bits hold the largest value the match counter reaches, N-1.
    localparam int unsigned   MW      = $clog2(LOCK_FRAMES);

    typedef enum logic [1:0] {
        StSearch,
        StMeasure,
        StLocked
    } state_e;

    state_e        state_q, state_d;
    logic [MW-1:0] match_cnt_q, match_cnt_d;

    // Edge-detect history
    logic hsync_q, vsync_q, de_q;

    // Line / frame measurement
    logic [CW-1:0] h_cnt_q;
    logic [CW-1:0] line_len_q;
    logic [CW-1:0] de_cnt_q;
    logic [CW-1:0] line_act_q;
    logic [CW-1:0] v_cnt_q;
    logic [CW-1:0] act_lines_q;
    logic          len_seen_q;
    logic          act_seen_q;
    logic          bad_q;

    // Snapshot of the previous frame's tuple
    logic [CW-1:0] snap_len_q, snap_v_q, snap_act_q, snap_alines_q;
    logic          snap_ok_q;

    // Registered outputs
    logic [CW-1:0] h_total_q, v_total_q, h_active_q, v_active_q;
    logic [CW-1:0] pixel_x_q;
    logic          pixel_valid_q;
    logic          frame_start_q;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] val);
        return (val == CNT_MAX) ? val : val + CW'(1);
    endfunction

    logic hrise, vrise, de_fall;
    assign hrise   = hsync & ~hsync_q;
    assign vrise   = vsync & ~vsync_q;
    assign de_fall = ~video_on & de_q;

    logic h_sat, de_sat, v_sat, al_sat;
    assign h_sat  = (h_cnt_q == CNT_MAX);
    assign de_sat = (de_cnt_q == CNT_MAX);
    assign v_sat  = (v_cnt_q == CNT_MAX);
    assign al_sat = (act_lines_q == CNT_MAX);

    logic [CW-1:0] new_len;
    assign new_len = h_sat ? CNT_MAX : h_cnt_q + CW'(1);

    // Tuple of the ending frame. Line events coincident with vrise belong to
    // the ending frame, so they are folded in here before the clear.
    logic [CW-1:0] cand_len, cand_v, cand_act, cand_alines;
    assign cand_len    = hrise   ? new_len           : line_len_q;
    assign cand_v      = hrise   ? sat_inc(v_cnt_q)  : v_cnt_q;
    assign cand_act    = de_fall ? de_cnt_q          : line_act_q;
    assign cand_alines = de_fall ? sat_inc(act_lines_q) : act_lines_q;

    // Anything that disqualifies the current frame, including this cycle.
    logic bad_evt, frame_bad;
    assign bad_evt = (hrise && len_seen_q && (new_len != line_len_q))
                   | (hrise && (new_len < CW'(H_MIN)))
                   | (de_fall && act_seen_q && (de_cnt_q != line_act_q))
                   | h_sat
                   | (video_on && de_sat)
                   | (hrise && v_sat)
                   | (de_fall && al_sat);
    assign frame_bad = bad_q | bad_evt;

    // A match needs both frames of the pair to be good, so LOCK_FRAMES-1
    // matches means LOCK_FRAMES consecutive identical good frames.
    logic frame_match;
    assign frame_match = snap_ok_q && !frame_bad
                       && (cand_len == snap_len_q) && (cand_v == snap_v_q)
                       && (cand_act == snap_act_q) && (cand_alines == snap_alines_q);

    logic upd_out;

    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        upd_out     = 1'b0;
        if (ce && vrise) begin
            unique case (state_q)
                StSearch: begin
                    state_d     = StMeasure;
                    match_cnt_d = '0;
                end
                StMeasure: begin
                    if (frame_match) begin
                        match_cnt_d = match_cnt_q + MW'(1);
                        if (match_cnt_d == MW'(LOCK_FRAMES - 1)) begin
                            state_d = StLocked;
                            upd_out = 1'b1;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                StLocked: begin
                    if (frame_match) begin
                        upd_out = 1'b1;
                    end else begin
                        state_d     = StMeasure;
                        match_cnt_d = '0;
                    end
                end
                default: begin
                    state_d     = StSearch;
                    match_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            state_q       <= StSearch;
            match_cnt_q   <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            de_q          <= 1'b0;
            h_cnt_q       <= '0;
            line_len_q    <= '0;
            de_cnt_q      <= '0;
            line_act_q    <= '0;
            v_cnt_q       <= '0;
            act_lines_q   <= '0;
            len_seen_q    <= 1'b0;
            act_seen_q    <= 1'b0;
            bad_q         <= 1'b0;
            snap_len_q    <= '0;
            snap_v_q      <= '0;
            snap_act_q    <= '0;
            snap_alines_q <= '0;
            snap_ok_q     <= 1'b0;
            h_total_q     <= '0;
            v_total_q     <= '0;
            h_active_q    <= '0;
            v_active_q    <= '0;
            pixel_x_q     <= '0;
            pixel_valid_q <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= ce & vrise;
            if (ce) begin
                state_q     <= state_d;
                match_cnt_q <= match_cnt_d;
                hsync_q     <= hsync;
                vsync_q     <= vsync;
                de_q        <= video_on;
                bad_q       <= frame_bad;

                pixel_valid_q <= locked & video_on;

                if (hrise) begin
                    line_len_q <= new_len;
                    h_cnt_q    <= '0;
                    len_seen_q <= 1'b1;
                    v_cnt_q    <= sat_inc(v_cnt_q);
                end else if (!h_sat) begin
                    h_cnt_q <= h_cnt_q + CW'(1);
                end

                if (video_on) begin
                    pixel_x_q <= de_cnt_q;
                    de_cnt_q  <= sat_inc(de_cnt_q);
                end else if (de_fall) begin
                    line_act_q  <= de_cnt_q;
                    de_cnt_q    <= '0;
                    act_seen_q  <= 1'b1;
                    act_lines_q <= sat_inc(act_lines_q);
                end

                // Frame boundary: overrides the per-line updates above.
                if (vrise) begin
                    v_cnt_q       <= '0;
                    act_lines_q   <= '0;
                    bad_q         <= 1'b0;
                    len_seen_q    <= 1'b0;
                    act_seen_q    <= 1'b0;
                    snap_len_q    <= cand_len;
                    snap_v_q      <= cand_v;
                    snap_act_q    <= cand_act;
                    snap_alines_q <= cand_alines;
                    // The frame ending at the first vrise is partial.
                    snap_ok_q     <= (state_q != StSearch) && !frame_bad;
                end

                if (upd_out) begin
                    h_total_q  <= cand_len;
                    v_total_q  <= cand_v;
                    h_active_q <= cand_act;
                    v_active_q <= cand_alines;
                end
            end
        end
    end

`ifdef HDMI_TIMING_DETECT_ERRCNT_EN
    logic       err_inc;
    logic [7:0] err_cnt_q;

    assign err_inc = ce & vrise & (state_q == StLocked) & (state_d != StLocked);

    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            err_cnt_q <= '0;
        end else if (err_inc && (err_cnt_q != 8'hff)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

    assign h_total     = h_total_q;
    assign v_total     = v_total_q;
    assign h_active    = h_active_q;
    assign v_active    = v_active_q;
    assign pixel_x     = pixel_x_q;
    // Row counter doubles as the active-line count for the frame.
    assign pixel_y     = act_lines_q;
    assign pixel_valid = pixel_valid_q;
    assign locked      = (state_q == StLocked);
    assign frame_start = frame_start_q;

endmodule

// File: doc/hdmi_timing_detect.md
# hdmi_timing_detect

Sync-side receiver for the StarSoC video timing path. It samples an incoming hsync/vsync/video_on stream in the pixel clock domain, gated by a clock enable, and measures the line and frame format. After several identical frames it declares lock, and then outputs recovered pixel coordinates for downstream capture or checking logic. It closes the loop on the display timing generator and serves as a bench monitor and as a front end for external video input.

## Interface
Parameters:
- CW, 11, width of all period/active counters and measured outputs
- LOCK_FRAMES, 2, consecutive identical complete frames required for lock (≥2)
- H_MIN, 16, minimum legal h_total in ce cycles

Ports:
- pixel_clk  in  1  pixel clock; single clock domain
- reset_n  in  1  synchronous, active-low reset; overrides ce
- ce  in  1  sample enable; all state advances only on cycles with ce=1
- hsync  in  1  line sync, active-high; rising edge = line start
- vsync  in  1  frame sync, active-high; rising edge = frame start
- video_on  in  1  active-pixel qualifier
- h_total  out  CW  ce cycles per line, last complete frame
- v_total  out  CW  hsync rises per frame, last complete frame
- h_active  out  CW  video_on cycles per active line
- v_active  out  CW  lines containing video_on per frame
- pixel_x  out  CW  active column, 0-based
- pixel_y  out  CW  active row, 0-based
- pixel_valid  out  1  locked & video_on, aligned with pixel_x/y
- locked  out  1  format stable
- frame_start  out  1  one-cycle pulse on each vsync rise
- err_count  out  8  lock-loss count (see Configuration)

## Operation
- Edge detect: hsync, vsync and video_on are registered on ce cycles. rise = in & ~prev; video_on fall = ~in & prev.
- h_cnt increments every ce cycle. On hrise: line_len <= h_cnt+1, then h_cnt <= 0. h_cnt saturates at 2^CW-1. Saturation marks the frame bad.
- de_cnt counts video_on cycles and drives pixel_x. On video_on fall: line_act <= de_cnt, de_cnt <= 0, pixel_y <= pixel_y+1, act_lines <= act_lines+1.
- v_cnt counts hrise events. An hrise coincident with vrise belongs to the ending frame.
- On vrise, the frame completes. Candidate tuple = (line_len, v_cnt, line_act, act_lines). The frame is bad if any of these occurred during it:
  - line_len varied between lines
  - line_act varied between active lines
  - line_len < H_MIN
  - any counter saturated
- After vrise: v_cnt, act_lines and pixel_y clear to 0, and the bad flag clears.
- FSM:
  - SEARCH: first vrise → MEASURE. No comparison on this vrise.
  - MEASURE:
    - Each vrise stores the tuple as the snapshot.
    - If the tuple equals the previous snapshot and the frame is good, match_cnt++. Otherwise match_cnt <= 0.
    - When match_cnt reaches LOCK_FRAMES-1 → LOCKED, locked=1.
  - LOCKED: a bad frame or a tuple mismatch → MEASURE, locked=0, match_cnt=0, and err_count increments.
- h_total/v_total/h_active/v_active update only on a LOCKED vrise, or on the MEASURE→LOCKED transition. They hold their values while unlocked.

## Timing
- Reset (reset_n=0 on a clock edge):
  - Every output goes to 0 and the FSM goes to SEARCH.
  - Edge registers load 0, so a high input at release produces a rise on the first ce cycle.
- Latency: pixel_x/pixel_y/pixel_valid trail the input by 1 pixel_clk on ce cycles. frame_start and locked update 1 cycle after the sampling ce cycle.
- ce=0: all registers hold and frame_start=0.
- Mid-operation reset: takes effect on the next edge, and the lock sequence restarts from SEARCH.
- Simultaneous vrise and video_on fall: the line is counted in the ending frame first.

## Configuration
- HDMI_TIMING_DETECT_ERRCNT_EN defined: err_count is an 8-bit counter that saturates at 255 and increments once per LOCKED→MEASURE transition.
- Macro undefined: err_count is tied to 0, the counter logic is omitted, and all other behaviour is identical.

## Test plan
- 800x525 total, 640x480 active, LOCK_FRAMES=2, ce every cycle:
  - locked rises 1 cycle after the 3rd vsync rise.
  - Outputs read h_total=800, v_total=525, h_active=640, v_active=480.
- Same stream with ce high every other cycle: identical measured values, and locked only after the same number of vsync rises.
- While locked, one line is lengthened to 801: at the next vsync rise locked falls and err_count=1. Re-lock occurs 2 frames later.
- While locked, check coordinates: the first active pixel gives pixel_x=0, pixel_y=0, pixel_valid=1. The last active pixel gives pixel_x=639, pixel_y=479.
- hsync stuck low for 2048 cycles: the frame is marked bad and locked stays 0.
- reset_n pulsed low mid-frame while locked: all outputs are 0 next cycle, and lock is reacquired after 3 vsync rises.
